// File: rtl/lsu_io_responder_if.sv
// Request/response bundle between the core M stage and the LSU I/O responder.
// The core side uses the master modport and the responder uses the slave modport.
interface lsu_io_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lsu_io_responder.sv
// M-stage load/store responder: byte-enable data RAM, red/green LED registers and
// a synchronized switch bank, with lane steering, extension and error checking.
module lsu_io_responder #(
  parameter int unsigned DMEM_WORDS     = 512,
  parameter int unsigned SW_SYNC_STAGES = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  lsu_io_responder_if.slave   bus,
  input  logic [31:0]         i_io_sw,
  output logic [31:0]         o_io_ledr,
  output logic [31:0]         o_io_ledg
);
  localparam int unsigned DMEM_AW = $clog2(DMEM_WORDS);
  localparam int unsigned DMEM_BW = DMEM_AW + 2;
  localparam logic [29:0] LEDR_WADDR = 30'h0400_0000;
  localparam logic [29:0] LEDG_WADDR = 30'h0400_0400;
  localparam logic [29:0] SW_WADDR   = 30'h0400_4000;

  logic               ready_reg;
  logic               accept;
  logic [31:0]        addr;
  logic [2:0]         funct3;
  logic               we;
  logic               sel_dmem, sel_ledr, sel_ledg, sel_sw;
  logic               f3_ok, misaligned, req_err;
  logic [3:0]         be;
  logic [31:0]        wlanes;
  logic               wr_ok;
  logic [3:0]         dmem_we;
  logic               ledr_we, ledg_we;
  logic [DMEM_AW-1:0] word_idx;
  logic [31:0]        dmem_q;

  logic [SW_SYNC_STAGES*32-1:0] sw_sync_reg;
  logic [31:0]        sw_last;

  logic               rsp_valid_reg;
  logic               rsp_err_reg;
  logic               rsp_load_reg;
  logic               rsp_dmem_reg;
  logic [2:0]         rsp_f3_reg;
  logic [1:0]         rsp_off_reg;
  logic [31:0]        io_word_reg;

  logic [31:0]        rsp_word;
  logic [31:0]        rsp_shifted;
  logic [31:0]        rsp_ext;

  assign addr     = bus.req_addr;
  assign funct3   = bus.req_funct3;
  assign we       = bus.req_we;
  assign word_idx = addr[DMEM_AW+1:2];
  assign accept   = bus.req_valid & ready_reg & ~i_rst;

  always_comb begin
    sel_dmem   = (addr[31:DMEM_BW] == '0);
    sel_ledr   = (addr[31:2] == LEDR_WADDR);
    sel_ledg   = (addr[31:2] == LEDG_WADDR);
    sel_sw     = (addr[31:2] == SW_WADDR);
    f3_ok      = 1'b0;
    misaligned = 1'b0;
    be         = 4'b1111;
    wlanes     = bus.req_wdata;
    case (funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = ~we;
      default:                f3_ok = 1'b0;
    endcase
    case (funct3[1:0])
      2'b00: begin
        be     = 4'b0001 << addr[1:0];
        wlanes = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = addr[0];
        be         = addr[1] ? 4'b1100 : 4'b0011;
        wlanes     = {2{bus.req_wdata[15:0]}};
      end
      default: misaligned = (addr[1:0] != 2'b00);
    endcase
    // Switches are read-only, so a store there is rejected like an unmapped access.
    req_err = ~f3_ok | misaligned | ~(sel_dmem | sel_ledr | sel_ledg | sel_sw) | (we & sel_sw);
    wr_ok   = accept & we & ~req_err;
    dmem_we = (wr_ok & sel_dmem) ? be : 4'b0000;
    ledr_we = wr_ok & sel_ledr;
    ledg_we = wr_ok & sel_ledg;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ready_reg <= 1'b0;
      sw_sync_reg <= '0;
    end else begin
      ready_reg <= 1'b1;
      if (SW_SYNC_STAGES > 1)
        sw_sync_reg <= {sw_sync_reg[SW_SYNC_STAGES*32-33:0], i_io_sw};
      else
        sw_sync_reg <= i_io_sw;
    end
  end

  assign sw_last = sw_sync_reg[SW_SYNC_STAGES*32-1 -: 32];

  // One byte-wide RAM and one byte of each LED register per lane.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DMEM_WORDS];
      logic [7:0] lane_q_reg;
      logic [7:0] ledr_lane_reg;
      logic [7:0] ledg_lane_reg;

      always_ff @(posedge i_clk) begin
        if (dmem_we[gi])
          mem[word_idx] <= wlanes[gi*8 +: 8];
        lane_q_reg <= mem[word_idx];
      end

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          ledr_lane_reg <= 8'h00;
          ledg_lane_reg <= 8'h00;
        end else begin
          if (ledr_we && be[gi])
            ledr_lane_reg <= wlanes[gi*8 +: 8];
          if (ledg_we && be[gi])
            ledg_lane_reg <= wlanes[gi*8 +: 8];
        end
      end

      assign dmem_q[gi*8 +: 8]    = lane_q_reg;
      assign o_io_ledr[gi*8 +: 8] = ledr_lane_reg;
      assign o_io_ledg[gi*8 +: 8] = ledg_lane_reg;
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_load_reg  <= 1'b0;
      rsp_dmem_reg  <= 1'b0;
      rsp_f3_reg    <= 3'b000;
      rsp_off_reg   <= 2'b00;
      io_word_reg   <= 32'h0;
    end else begin
      rsp_valid_reg <= accept;
      rsp_err_reg   <= accept & req_err;
      rsp_load_reg  <= accept & ~we & ~req_err;
      rsp_dmem_reg  <= sel_dmem;
      rsp_f3_reg    <= funct3;
      rsp_off_reg   <= addr[1:0];
      // LED values are captured before any same-edge store lands.
      io_word_reg   <= sel_ledr ? o_io_ledr : (sel_ledg ? o_io_ledg : sw_last);
    end
  end

  always_comb begin
    rsp_word    = rsp_dmem_reg ? dmem_q : io_word_reg;
    rsp_shifted = rsp_word >> {rsp_off_reg, 3'b000};
    case (rsp_f3_reg)
      3'b000:  rsp_ext = {{24{rsp_shifted[7]}}, rsp_shifted[7:0]};
      3'b001:  rsp_ext = {{16{rsp_shifted[15]}}, rsp_shifted[15:0]};
      3'b100:  rsp_ext = {24'h0, rsp_shifted[7:0]};
      3'b101:  rsp_ext = {16'h0, rsp_shifted[15:0]};
      default: rsp_ext = rsp_word;
    endcase
  end

  // Reset masks a response that is still on the wire when reset asserts.
  assign bus.req_ready = ready_reg;
  assign bus.rsp_valid = rsp_valid_reg & ~i_rst;
  assign bus.rsp_err   = rsp_err_reg & ~i_rst;
  assign bus.rsp_rdata = (rsp_load_reg & ~i_rst) ? rsp_ext : 32'h0;
endmodule

// File: tb/tb_lsu_io_responder.sv
// Directed bench for lsu_io_responder: reset, DMEM lanes, back-to-back RAW, LEDs,
// switch synchronizer, error cases and reset cancellation of a pending response.
module tb_lsu_io_responder;
  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_io_sw;
  logic [31:0] o_io_ledr;
  logic [31:0] o_io_ledg;

  lsu_io_responder_if bus ();

  lsu_io_responder #(.DMEM_WORDS(512), .SW_SYNC_STAGES(2)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .bus       (bus),
    .i_io_sw   (i_io_sw),
    .o_io_ledr (o_io_ledr),
    .o_io_ledg (o_io_ledg)
  );

  always #5 i_clk = ~i_clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        rv, re;
  logic [31:0] rd;

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Presents one request for exactly one edge and samples the response cycle.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    @(negedge i_clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = st;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge i_clk);
    #1;
    rv = bus.rsp_valid;
    rd = bus.rsp_rdata;
    re = bus.rsp_err;
    bus.req_valid = 1'b0;
  endtask

  task automatic load_ok(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp);
    issue(1'b0, f3, a, 32'h0);
    check_eq({tag, " valid"}, {31'h0, rv}, 32'h1);
    check_eq({tag, " err"}, {31'h0, re}, 32'h0);
    check_eq({tag, " rdata"}, rd, exp);
  endtask

  task automatic store_ok(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    issue(1'b1, f3, a, wd);
    check_eq({tag, " valid"}, {31'h0, rv}, 32'h1);
    check_eq({tag, " err"}, {31'h0, re}, 32'h0);
    check_eq({tag, " rdata"}, rd, 32'h0);
  endtask

  task automatic req_err(input string tag, input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    issue(st, f3, a, wd);
    check_eq({tag, " valid"}, {31'h0, rv}, 32'h1);
    check_eq({tag, " err"}, {31'h0, re}, 32'h1);
    check_eq({tag, " rdata"}, rd, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst          = 1'b1;
    i_io_sw        = 32'h0;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F_W;
    bus.req_addr   = 32'h1000_0000;
    bus.req_wdata  = 32'hFFFF_FFFF;

    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk);
      #1;
      check_eq("rst ready", {31'h0, bus.req_ready}, 32'h0);
      check_eq("rst rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
      check_eq("rst ledr", o_io_ledr, 32'h0);
    end
    check_eq("rst ledg", o_io_ledg, 32'h0);
    check_eq("rst rdata", bus.rsp_rdata, 32'h0);
    check_eq("rst err", {31'h0, bus.rsp_err}, 32'h0);

    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    check_eq("release ready", {31'h0, bus.req_ready}, 32'h1);
    check_eq("release no accept", {31'h0, bus.rsp_valid}, 32'h0);
    check_eq("release ledr", o_io_ledr, 32'h0);
    bus.req_valid = 1'b0;

    // DMEM lanes
    store_ok("sw dmem 0x10", F_W, 32'h10, 32'hDEAD_BEEF);
    store_ok("sb dmem 0x12", F_B, 32'h12, 32'h0000_0055);
    load_ok("lw 0x10", F_W, 32'h10, 32'hDE55_BEEF);
    load_ok("lb 0x13", F_B, 32'h13, 32'hFFFF_FFDE);
    load_ok("lbu 0x13", F_BU, 32'h13, 32'h0000_00DE);
    load_ok("lb 0x12", F_B, 32'h12, 32'h0000_0055);
    load_ok("lh 0x10", F_H, 32'h10, 32'hFFFF_BEEF);
    load_ok("lhu 0x10", F_HU, 32'h10, 32'h0000_BEEF);
    load_ok("lhu 0x12", F_HU, 32'h12, 32'h0000_DE55);

    // Back-to-back store then load to the same word
    issue(1'b1, F_W, 32'h20, 32'h1234_5678);
    check_eq("b2b store valid", {31'h0, rv}, 32'h1);
    issue(1'b0, F_W, 32'h20, 32'h0);
    check_eq("b2b load valid", {31'h0, rv}, 32'h1);
    check_eq("b2b load rdata", rd, 32'h1234_5678);
    @(posedge i_clk);
    #1;
    check_eq("b2b idle valid", {31'h0, bus.rsp_valid}, 32'h0);
    check_eq("idle rdata", bus.rsp_rdata, 32'h0);

    // DMEM top word and first unmapped byte past it
    store_ok("sw dmem top", F_W, 32'h7FC, 32'hCAFE_F00D);
    load_ok("lw dmem top", F_W, 32'h7FC, 32'hCAFE_F00D);
    req_err("lw past dmem", 1'b0, F_W, 32'h800, 32'h0);

    // LEDs
    store_ok("sw ledr", F_W, 32'h1000_0000, 32'h0000_00FF);
    check_eq("ledr after sw", o_io_ledr, 32'h0000_00FF);
    store_ok("sh ledg hi", F_H, 32'h1000_1002, 32'h0000_ABCD);
    check_eq("ledg after sh", o_io_ledg, 32'hABCD_0000);
    load_ok("lw ledg", F_W, 32'h1000_1000, 32'hABCD_0000);
    store_ok("sb ledr b1", F_B, 32'h1000_0001, 32'h0000_0012);
    check_eq("ledr after sb", o_io_ledr, 32'h0000_12FF);
    load_ok("lbu ledr b1", F_BU, 32'h1000_0001, 32'h0000_0012);
    req_err("sw ledr misaligned", 1'b1, F_W, 32'h1000_0002, 32'hFFFF_FFFF);
    check_eq("ledr unchanged", o_io_ledr, 32'h0000_12FF);

    // Switches
    @(negedge i_clk);
    i_io_sw = 32'hA5A5_A5A5;
    repeat (2) @(posedge i_clk);
    load_ok("lw sw", F_W, 32'h1001_0000, 32'hA5A5_A5A5);
    load_ok("lh sw hi", F_H, 32'h1001_0002, 32'hFFFF_A5A5);
    req_err("store to sw", 1'b1, F_W, 32'h1001_0000, 32'h0000_0000);
    load_ok("lw sw after store", F_W, 32'h1001_0000, 32'hA5A5_A5A5);

    // Errors leave state untouched
    req_err("lw misaligned", 1'b0, F_W, 32'h11, 32'h0);
    req_err("sh misaligned", 1'b1, F_H, 32'h13, 32'h0000_FFFF);
    req_err("load funct3 011", 1'b0, 3'b011, 32'h10, 32'h0);
    req_err("store funct3 011", 1'b1, 3'b011, 32'h10, 32'h0);
    req_err("store funct3 100", 1'b1, F_BU, 32'h10, 32'h0);
    req_err("sw unmapped", 1'b1, F_W, 32'h2000_0000, 32'h1111_1111);
    req_err("lw unmapped", 1'b0, F_W, 32'h2000_0000, 32'h0);
    load_ok("lw 0x10 after errs", F_W, 32'h10, 32'hDE55_BEEF);

    // Reset during a pending response cancels it
    issue(1'b0, F_W, 32'h10, 32'h0);
    i_rst = 1'b1;
    #1;
    check_eq("rst cancel valid", {31'h0, bus.rsp_valid}, 32'h0);
    check_eq("rst cancel rdata", bus.rsp_rdata, 32'h0);
    @(posedge i_clk);
    #1;
    check_eq("rst2 rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check_eq("rst2 ready", {31'h0, bus.req_ready}, 32'h0);
    check_eq("rst2 ledr", o_io_ledr, 32'h0);
    check_eq("rst2 ledg", o_io_ledg, 32'h0);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    check_eq("rst2 release ready", {31'h0, bus.req_ready}, 32'h1);
    load_ok("lw 0x10 after rst", F_W, 32'h10, 32'hDE55_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
